// File: rtl/lock_sequencer.sv
// Combination-lock sequencer: per-digit BCD entry, attempt evaluation, fail counting and code reprogramming.
// Define LOCK_SEQUENCER_LOCKOUT_EN to add the timed LOCKOUT state after MAX_FAILS consecutive failures.
module lock_sequencer #(
    parameter int                      NUM_DIGITS     = 6,
    parameter logic [4*NUM_DIGITS-1:0] RESET_CODE     = 24'h722297,
    parameter int                      MAX_FAILS      = 3,
    parameter int                      LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       clear,
    input  logic       prog_req,
    output logic [2:0] status,
    output logic [2:0] digit_idx,
    output logic       unlocked,
    output logic       bad_digit,
    output logic [3:0] fail_cnt
);
    localparam int         CODE_W   = 4 * NUM_DIGITS;
    localparam int         SH_W     = CODE_W - 4;
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [3:0] FAIL_MAX = 4'(MAX_FAILS);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_CLOSED  = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROG    = 3'd4
    } state_e;

    // Digit idx of the code, counted from the most significant nibble.
    function automatic logic [3:0] code_nibble(input logic [CODE_W-1:0] code, input logic [2:0] idx);
        logic [CODE_W-1:0] shifted;
        shifted = code >> (4 * (NUM_DIGITS - 1 - int'(idx)));
        return shifted[3:0];
    endfunction

    state_e            state_q;
    logic [2:0]        idx_q;
    logic [3:0]        fail_q;
    logic              bad_q;
    logic              unlocked_q;
    logic              mismatch_q;
    logic [CODE_W-1:0] code_q;
    logic [SH_W-1:0]   shadow_q;
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
    localparam int              TMR_W     = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES);
    logic [TMR_W-1:0]           timer_q;
`endif

    logic       digit_bad_s;
    logic       digit_miss_s;
    logic       last_digit_s;
    logic [3:0] fail_inc_s;

    assign digit_bad_s  = (digit > 4'd9);
    assign digit_miss_s = digit_bad_s || (digit != code_nibble(code_q, idx_q));
    assign last_digit_s = (idx_q == IDX_LAST);
    assign fail_inc_s   = (fail_q >= FAIL_MAX) ? FAIL_MAX : (fail_q + 4'd1);

    // Sequencer FSM with all outputs held in registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ENTRY;
            idx_q      <= 3'd0;
            fail_q     <= 4'd0;
            bad_q      <= 1'b0;
            unlocked_q <= 1'b0;
            mismatch_q <= 1'b0;
            code_q     <= RESET_CODE;
            shadow_q   <= '0;
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            bad_q <= 1'b0;
            case (state_q)
                ST_ENTRY: begin
                    if (clear) begin
                        idx_q      <= 3'd0;
                        mismatch_q <= 1'b0;
                    end else if (digit_valid) begin
                        bad_q <= digit_bad_s;
                        if (last_digit_s) begin
                            idx_q      <= 3'd0;
                            mismatch_q <= 1'b0;
                            if (!(mismatch_q || digit_miss_s)) begin
                                state_q    <= ST_OPEN;
                                unlocked_q <= 1'b1;
                                fail_q     <= 4'd0;
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
                            end else if ((fail_q + 4'd1) == FAIL_MAX) begin
                                state_q <= ST_LOCKOUT;
                                timer_q <= TMR_LOAD;
                                fail_q  <= FAIL_MAX;
`endif
                            end else begin
                                state_q <= ST_CLOSED;
                                fail_q  <= fail_inc_s;
                            end
                        end else begin
                            idx_q      <= idx_q + 3'd1;
                            mismatch_q <= mismatch_q || digit_miss_s;
                        end
                    end else begin
                        idx_q <= idx_q;
                    end
                end
                ST_OPEN: begin
                    if (clear) begin
                        state_q    <= ST_ENTRY;
                        unlocked_q <= 1'b0;
                    end else if (prog_req) begin
                        state_q    <= ST_PROG;
                        unlocked_q <= 1'b0;
                        idx_q      <= 3'd0;
                        shadow_q   <= '0;
                    end else begin
                        state_q <= ST_OPEN;
                    end
                end
                ST_CLOSED: begin
                    if (clear) begin
                        state_q <= ST_ENTRY;
                    end else begin
                        state_q <= ST_CLOSED;
                    end
                end
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (timer_q == TMR_W'(1)) begin
                        state_q <= ST_CLOSED;
                        fail_q  <= 4'd0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
`endif
                ST_PROG: begin
                    // Any abort returns to OPEN with the stored code untouched.
                    if (clear) begin
                        state_q    <= ST_OPEN;
                        unlocked_q <= 1'b1;
                        idx_q      <= 3'd0;
                    end else if (digit_valid) begin
                        if (digit_bad_s) begin
                            bad_q      <= 1'b1;
                            state_q    <= ST_OPEN;
                            unlocked_q <= 1'b1;
                            idx_q      <= 3'd0;
                        end else if (last_digit_s) begin
                            code_q     <= {shadow_q, digit};
                            state_q    <= ST_OPEN;
                            unlocked_q <= 1'b1;
                            idx_q      <= 3'd0;
                        end else begin
                            shadow_q <= SH_W'({shadow_q, digit});
                            idx_q    <= idx_q + 3'd1;
                        end
                    end else begin
                        idx_q <= idx_q;
                    end
                end
                default: begin
                    state_q    <= ST_ENTRY;
                    idx_q      <= 3'd0;
                    unlocked_q <= 1'b0;
                    mismatch_q <= 1'b0;
                end
            endcase
        end
    end

    assign status    = state_q;
    assign digit_idx = idx_q;
    assign unlocked  = unlocked_q;
    assign bad_digit = bad_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed scenarios plus random traffic against a queue-based reference model.
module tb_lock_sequencer;
    localparam int          N  = 6;
    localparam logic [23:0] RC = 24'h722297;
    localparam int          MF = 3;
    localparam int          LC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       clear = 1'b0;
    logic       prog_req = 1'b0;
    logic [2:0] status;
    logic [2:0] digit_idx;
    logic       unlocked;
    logic       bad_digit;
    logic [3:0] fail_cnt;

    lock_sequencer #(
        .NUM_DIGITS(N), .RESET_CODE(RC), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .clear(clear), .prog_req(prog_req), .status(status), .digit_idx(digit_idx),
        .unlocked(unlocked), .bad_digit(bad_digit), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Reference model: 0 ENTRY, 1 OPEN, 2 CLOSED, 3 LOCKOUT, 4 PROG
    int m_state;
    int m_fail;
    int m_lock;
    int m_bad;
    int m_code[N];
    int eq[$];
    int pq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        logic [23:0] rv;
        rv = RC;
        m_state = 0; m_fail = 0; m_lock = 0; m_bad = 0;
        eq.delete(); pq.delete();
        for (int i = 0; i < N; i++) m_code[i] = int'(rv[4*(N-1-i) +: 4]);
    endtask

    task automatic model_step(input bit clr, input bit prg, input bit dv, input int d);
        bit ok;
        m_bad = 0;
        case (m_state)
            0: begin
                if (clr) eq.delete();
                else if (dv) begin
                    m_bad = (d > 9) ? 1 : 0;
                    eq.push_back(d);
                    if (eq.size() == N) begin
                        ok = 1'b1;
                        for (int i = 0; i < N; i++) if (eq[i] != m_code[i]) ok = 1'b0;
                        eq.delete();
                        if (ok) begin
                            m_state = 1; m_fail = 0;
                        end else begin
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
                            if (m_fail + 1 == MF) begin
                                m_state = 3; m_lock = LC; m_fail = MF;
                            end else begin
                                m_state = 2; m_fail++;
                            end
`else
                            m_state = 2;
                            if (m_fail < MF) m_fail++;
`endif
                        end
                    end
                end
            end
            1: begin
                if (clr) m_state = 0;
                else if (prg) begin m_state = 4; pq.delete(); end
            end
            2: if (clr) m_state = 0;
            3: begin
                m_lock--;
                if (m_lock == 0) begin m_state = 2; m_fail = 0; end
            end
            4: begin
                if (clr) begin m_state = 1; pq.delete(); end
                else if (dv) begin
                    if (d > 9) begin
                        m_bad = 1; m_state = 1; pq.delete();
                    end else begin
                        pq.push_back(d);
                        if (pq.size() == N) begin
                            for (int i = 0; i < N; i++) m_code[i] = pq[i];
                            pq.delete(); m_state = 1;
                        end
                    end
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_all(input string ph);
        int exp_idx;
        exp_idx = (m_state == 0) ? eq.size() : (m_state == 4) ? pq.size() : 0;
        chk({ph, ".status"}, 32'(status), m_state);
        chk({ph, ".digit_idx"}, 32'(digit_idx), exp_idx);
        chk({ph, ".unlocked"}, 32'(unlocked), (m_state == 1) ? 1 : 0);
        chk({ph, ".bad_digit"}, 32'(bad_digit), m_bad);
        chk({ph, ".fail_cnt"}, 32'(fail_cnt), m_fail);
    endtask

    task automatic cycle(input bit clr, input bit prg, input bit dv, input logic [3:0] d);
        clear = clr; prog_req = prg; digit_valid = dv; digit = d;
        @(posedge clk);
        model_step(clr, prg, dv, int'(d));
        #1;
        check_all("cyc");
    endtask

    task automatic enter_code(input logic [23:0] c);
        logic [23:0] v;
        v = c;
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, v[4*(N-1-i) +: 4]);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic mid_cycle_reset(input string ph);
        #2 rst = 1'b1;
        #1;
        chk({ph, ".status"}, 32'(status), 0);
        chk({ph, ".digit_idx"}, 32'(digit_idx), 0);
        chk({ph, ".unlocked"}, 32'(unlocked), 0);
        chk({ph, ".bad_digit"}, 32'(bad_digit), 0);
        chk({ph, ".fail_cnt"}, 32'(fail_cnt), 0);
        model_reset();
        clear = 1'b0; prog_req = 1'b0; digit_valid = 1'b0; digit = 4'd0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bit rc, rp, rv;
        logic [3:0] rd;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all("reset");

        // Correct code opens and stays open while idle
        enter_code(24'h722297);
        chk("open.status", 32'(status), 1);
        chk("open.unlocked", 32'(unlocked), 1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 4'd0);
        chk("open_idle.status", 32'(status), 1);

        // Wrong attempts
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        enter_code(24'h722296);
        chk("wrong1.status", 32'(status), 2);
        chk("wrong1.fail_cnt", 32'(fail_cnt), 1);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        chk("clr.digit_idx", 32'(digit_idx), 0);
        enter_code(24'h722296);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        enter_code(24'h111111);
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
        chk("lock.status", 32'(status), 3);
        chk("lock.fail_cnt", 32'(fail_cnt), 3);
        for (int i = 0; i < LC - 1; i++) begin
            cycle(1'b0, 1'b0, (i % 2) == 0, 4'd7);
            chk("lock_hold.status", 32'(status), 3);
        end
        cycle(1'b0, 1'b0, 1'b1, 4'd7);
        chk("lock_exit.status", 32'(status), 2);
        chk("lock_exit.fail_cnt", 32'(fail_cnt), 0);
`else
        chk("nolock.status", 32'(status), 2);
        chk("nolock.fail_cnt", 32'(fail_cnt), 3);
        for (int i = 0; i < LC; i++) cycle(1'b0, 1'b0, (i % 2) == 0, 4'd7);
        chk("nolock_hold.status", 32'(status), 2);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        enter_code(24'h000000);
        chk("fail_sat.fail_cnt", 32'(fail_cnt), 3);
`endif

        // Reprogram to 123456
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        enter_code(24'h722297);
        cycle(1'b0, 1'b1, 1'b0, 4'd0);
        chk("prog.status", 32'(status), 4);
        enter_code(24'h123456);
        chk("prog_done.status", 32'(status), 1);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        enter_code(24'h123456);
        chk("newcode.status", 32'(status), 1);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        enter_code(24'h722297);
        chk("oldcode.status", 32'(status), 2);

        // Async reset mid-attempt restores the reset code
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b0, 1'b1, 4'(i));
        mid_cycle_reset("rst_entry");
        enter_code(24'h722297);
        chk("revert.status", 32'(status), 1);

        // Async reset mid-program
        cycle(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 4'd5);
        chk("prog4.digit_idx", 32'(digit_idx), 4);
        mid_cycle_reset("rst_prog");
        enter_code(24'h722297);
        chk("revert2.status", 32'(status), 1);

        // Invalid digit in ENTRY
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 4'd7);
        cycle(1'b0, 1'b0, 1'b1, 4'd10);
        chk("bad_entry.bad_digit", 32'(bad_digit), 1);
        chk("bad_entry.digit_idx", 32'(digit_idx), 2);
        cycle(1'b0, 1'b0, 1'b1, 4'd2);
        chk("bad_entry_end.bad_digit", 32'(bad_digit), 0);
        cycle(1'b0, 1'b0, 1'b1, 4'd2);
        cycle(1'b0, 1'b0, 1'b1, 4'd9);
        cycle(1'b0, 1'b0, 1'b1, 4'd7);
        chk("bad_entry_done.status", 32'(status), 2);

        // Invalid digit in PROG aborts without changing the code
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        enter_code(24'h722297);
        cycle(1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 4'd1);
        cycle(1'b0, 1'b0, 1'b1, 4'd12);
        chk("bad_prog.bad_digit", 32'(bad_digit), 1);
        chk("bad_prog.status", 32'(status), 1);
        cycle(1'b0, 1'b0, 1'b0, 4'd0);
        chk("bad_prog_end.bad_digit", 32'(bad_digit), 0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        enter_code(24'h722297);
        chk("bad_prog_code.status", 32'(status), 1);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            rc = ($urandom_range(0, 19) == 0);
            rp = ($urandom_range(0, 7) == 0);
            rv = !rp && ($urandom_range(0, 1) == 1);
            if (m_state == 0 && eq.size() < N && $urandom_range(0, 3) != 0)
                rd = 4'(m_code[eq.size()]);
            else if (m_state == 4 && $urandom_range(0, 7) != 0)
                rd = 4'($urandom_range(0, 9));
            else
                rd = 4'($urandom_range(0, 15));
            cycle(rc, rp, rv, rd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Sequences the combination-lock datapath: consumes one BCD digit per strobe, compares it against a stored N-digit code, tracks failed attempts, enforces a lockout period, and supports reprogramming the code while open.
- Sits between the debounced key/switch front end and the HEX display decoder.
- Its `status` output selects what the decoder shows: the digit, OPEn, CLOSEd, ErrOr, a lockout message or a program-mode message.

Parameters:
- NUM_DIGITS, 6: digits per combination (2..8).
- RESET_CODE, 24'h722297: code loaded at reset, BCD, 4*NUM_DIGITS bits; the first digit entered is the MS nibble.
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout (1..15).
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- digit_valid  in  1  one-cycle strobe: `digit` is presented this cycle.
- digit  in  4  entered value; 0..9 valid, 10..15 invalid.
- clear  in  1  abort/relock request.
- prog_req  in  1  request to reprogram the code; honoured only in OPEN.
- status  out  3  0 ENTRY, 1 OPEN, 2 CLOSED, 3 LOCKOUT, 4 PROG.
- digit_idx  out  3  digits accepted in the current attempt or programming pass.
- unlocked  out  1  high iff state is OPEN.
- bad_digit  out  1  one-cycle pulse, cycle after an invalid digit is strobed in ENTRY or PROG.
- fail_cnt  out  4  consecutive failed attempts.

Behaviour:
- Reset (async, immediate, from any state, including mid-attempt or mid-program):
  - State = ENTRY; digit_idx = 0; fail_cnt = 0; bad_digit = 0; unlocked = 0.
  - Code register = RESET_CODE; mismatch flag = 0; lockout timer = 0.
- All outputs are registered and reflect the state after the clock edge that consumed the input.
- Input priority each cycle: clear > prog_req > digit_valid.
- ENTRY:
  - digit_valid: compare `digit` with code nibble [4*(NUM_DIGITS-digit_idx)-1 -: 4].
  - On a mismatch, or if digit > 9, set the sticky mismatch flag; an invalid digit also pulses bad_digit. The digit is consumed either way and digit_idx increments.
  - On the strobe that makes digit_idx reach NUM_DIGITS, evaluate the attempt:
    - No mismatch: go to OPEN; fail_cnt = 0.
    - Mismatch and fail_cnt+1 == MAX_FAILS: go to LOCKOUT; timer = LOCKOUT_CYCLES; fail_cnt = MAX_FAILS.
    - Mismatch otherwise: go to CLOSED; fail_cnt++.
  - digit_idx and the mismatch flag are cleared on every exit from ENTRY.
  - clear: digit_idx = 0, mismatch = 0, stay in ENTRY. This does not count as a failure.
- OPEN:
  - clear: go to ENTRY (relock).
  - prog_req: go to PROG with digit_idx = 0.
  - digit_valid: ignored.
- CLOSED:
  - clear: go to ENTRY.
  - digit_valid and prog_req: ignored (the digit is not consumed).
- LOCKOUT:
  - The timer decrements every cycle; all inputs are ignored.
  - On the cycle the timer reads 1, the next state is CLOSED and fail_cnt = 0.
  - Total time in LOCKOUT is exactly LOCKOUT_CYCLES cycles.
- PROG:
  - A valid digit shifts into a shadow register (MS first); digit_idx++.
  - On the NUM_DIGITS-th valid digit, the shadow register is copied to the code register in the same edge, and the state goes to OPEN.
  - An invalid digit pulses bad_digit and aborts to OPEN; the code is unchanged.
  - clear aborts to OPEN; the code is unchanged.
- Width rules:
  - digit_idx never exceeds NUM_DIGITS.
  - fail_cnt saturates at MAX_FAILS.
  - The timer is sized as clog2(LOCKOUT_CYCLES+1).
- No state produces status values 5..7.

Optional Feature:
- Macro: LOCK_SEQUENCER_LOCKOUT_EN.
- Defined: LOCKOUT state and timer are present as described above.
- Undefined:
  - No LOCKOUT state and no timer logic; status never equals 3.
  - Failed attempts always go to CLOSED, and fail_cnt saturates at MAX_FAILS.

Test Plan:
- Reset, strobe 7,2,2,2,9,7 one per cycle -> after the 6th edge: status=1, unlocked=1, fail_cnt=0; 3 idle cycles -> still OPEN.
- Reset, strobe 7,2,2,2,9,6 -> status=2, fail_cnt=1, unlocked=0. clear -> status=0, digit_idx=0.
- Three wrong attempts (with clear between them) -> status=3, fail_cnt=3. Hold for 16 cycles with digit_valid toggling -> status=3 throughout, then status=2, fail_cnt=0. With the macro undefined, the same stimulus -> status=2, fail_cnt=3.
- Open with 722297, prog_req, strobe 1,2,3,4,5,6 -> OPEN. clear, enter 123456 -> OPEN; clear, enter 722297 -> CLOSED.
- In ENTRY, strobe digit 10 as the 2nd digit -> bad_digit high for exactly 1 cycle, digit_idx=2. Completing with 2,2,9,7 -> CLOSED. In PROG, strobe 12 -> bad_digit pulse, OPEN, code unchanged.
- Assert rst asynchronously (mid-cycle) after 3 digits, and separately after 4 program digits -> outputs reset immediately without a clock edge. Then entering 722297 -> OPEN, confirming the code reverted to RESET_CODE.
